stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//  Mode controller for the MM:SS stopwatch. Owns the live BCD time register and advances it on tick_1hz
//  while running. Sequences IDLE/RUN/PAUSE/SET/ALARM from one-cycle button pulses and stores lap times.
//  Compares against a user-set target time and selects what the 7-seg display driver shows.
// PARAMETERS
//  LAP_DEPTH   4   number of lap entries kept; oldest is overwritten when full; >=1
// PORTS
//  CLK1        in   1   system clock
//  RESET       in   1   synchronous, active-high reset
//  tick_1hz    in   1   one-CLK1-cycle pulse per second
//  btn_start   in   1   pulse: start/stop toggle, also alarm acknowledge
//  btn_lap     in   1   pulse: record lap (RUN) / step lap view (PAUSE)
//  btn_clear   in   1   pulse: return to IDLE, zero time, empty laps
//  btn_set     in   1   pulse: enter/leave SET mode
//  btn_sel     in   1   pulse: SET cursor to next digit
//  btn_inc     in   1   pulse: SET increment digit under cursor
//  disp_min10/min01/sec10/sec01  out  4 each  BCD digits to display
//  cursor      out  2   SET digit index: 0=sec01 1=sec10 2=min01 3=min10
//  state       out  3   current FSM state code (encoding in stopwatch_pkg)
//  running     out  1   1 only in RUN
//  alarm       out  1   1 only in ALARM
//  overflow    out  1   sticky: time wrapped 59:59->00:00 since last clear
//  lap_cnt     out  $clog2(LAP_DEPTH+1)  laps stored, saturates at LAP_DEPTH
//  lap_view    out  1   display currently shows a stored lap
// BEHAVIOUR
//  - Reset: state IDLE; time, target, lap store 00:00; cursor 0; lap_cnt 0; overflow, lap_view 0.
//  - Same-cycle button priority: clear > set > start > lap; sel/inc only act in SET. Lower-priority pulses dropped.
//  - btn_clear (any state except SET): ->IDLE, time=00:00, lap_cnt=0, overflow=0, lap_view=0; target kept.
//  - IDLE: start->RUN; set->SET. Time stays 00:00.
//  - RUN: on tick, time<=inc(time) next edge (1-cycle latency). Digit limits 9/5/9/5; 59:59 wraps to 00:00, sets overflow.
//    If target!=00:00 and inc(time)==target on a tick: time<=target, ->ALARM same edge.
//    start->PAUSE; a tick in that same cycle is still applied.
//    lap: push pre-increment time (value before any same-cycle tick) into circular store; lap_cnt+1 saturating.
//  - PAUSE: ticks ignored. start->RUN (lap_view cleared). lap: if lap_cnt==0 ignore; else step view
//    live -> lap 0 (oldest) -> ... -> lap lap_cnt-1 -> live.
//  - SET: ticks ignored; time frozen. sel: cursor+1 mod 4. inc: target digit under cursor +1, wraps at its limit
//    (9->0 or 5->0), no carry to neighbours. set-> IDLE, cursor kept. start/lap/clear ignored in SET.
//  - ALARM: alarm=1, time holds target, ticks ignored. start or clear ->IDLE with time=00:00.
//  - Display mux, registered, shows state after the edge: SET->target; PAUSE&lap_view->selected lap; else->time.
//  - All outputs registered; no combinational path from inputs to outputs. Reset mid-RUN takes priority over tick.
// STRUCTURE
//  - stopwatch_pkg: state enum (IDLE,RUN,PAUSE,SET,ALARM), digit-limit constants (SEC10_MAX=5,
//    MIN10_MAX=5, UNIT_MAX=9), cursor index constants, mmss_t struct of four 4-bit BCD digits.
//  - Sub-module bcd_mmss_inc: combinational mmss_t -> mmss_t +1 s with wrap flag; also exercised standalone.
//  - Lap store: LAP_DEPTH x 16-bit register array, write pointer mod LAP_DEPTH; oldest = wr_ptr when full, else 0.
// TESTING
//  - Reset, start, 3 ticks -> disp 00:03, running=1; start -> PAUSE, further ticks leave 00:03.
//  - Preload run to 59:58, 2 ticks -> 59:59 then 00:00, overflow=1; clear -> overflow=0, disp 00:00.
//  - SET: cursor to 1, inc x6 -> sec10 wraps 5->0; set target 00:05; run 5 ticks -> alarm=1, disp 00:05;
//    6th tick no change; start -> IDLE 00:00.
//  - LAP_DEPTH=4: laps at 00:01..00:05 -> lap_cnt=4; PAUSE, lap steps 00:02,00:03,00:04,00:05 then live.
//  - Same cycle tick+lap at 00:07 -> lap stores 00:07, disp 00:08; start+clear together -> IDLE only.
//  - RESET asserted mid-RUN coincident with tick -> all outputs reset values next edge, state IDLE.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch controller.
//   sw_state_e : FSM state encoding, also driven on the 'state' output.
//   mmss_t     : four packed BCD digits, min10 in the top nibble.
//   *_MAX      : highest legal value of each digit position.
//   CUR_*      : SET-mode cursor index for each digit.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRun   = 3'd1,
    StPause = 3'd2,
    StSet   = 3'd3,
    StAlarm = 3'd4
  } sw_state_e;

  localparam logic [3:0] SEC10_MAX = 4'd5;
  localparam logic [3:0] MIN10_MAX = 4'd5;
  localparam logic [3:0] UNIT_MAX  = 4'd9;

  localparam logic [1:0] CUR_SEC01 = 2'd0;
  localparam logic [1:0] CUR_SEC10 = 2'd1;
  localparam logic [1:0] CUR_MIN01 = 2'd2;
  localparam logic [1:0] CUR_MIN10 = 2'd3;

  typedef struct packed {
    logic [3:0] min10;
    logic [3:0] min01;
    logic [3:0] sec10;
    logic [3:0] sec01;
  } mmss_t;

  // Digit +1 wrapping to 0 past max_d; out-of-range digits also fold back to 0.
  function automatic logic [3:0] digit_inc_wrap(input logic [3:0] d, input logic [3:0] max_d);
    return (d >= max_d) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_mmss_inc.sv
// Combinational +1 second on an MM:SS BCD value.
//   t_i    : current time
//   t_o    : time + 1 s, wrapping 59:59 -> 00:00
//   wrap_o : high when the increment wrapped past 59:59
module bcd_mmss_inc
  import stopwatch_pkg::*;
(
  input  mmss_t t_i,
  output mmss_t t_o,
  output logic  wrap_o
);

  always_comb begin
    t_o       = t_i;
    wrap_o    = 1'b0;
    t_o.sec01 = digit_inc_wrap(t_i.sec01, UNIT_MAX);
    if (t_i.sec01 >= UNIT_MAX) begin
      t_o.sec10 = digit_inc_wrap(t_i.sec10, SEC10_MAX);
      if (t_i.sec10 >= SEC10_MAX) begin
        t_o.min01 = digit_inc_wrap(t_i.min01, UNIT_MAX);
        if (t_i.min01 >= UNIT_MAX) begin
          t_o.min10 = digit_inc_wrap(t_i.min10, MIN10_MAX);
          wrap_o    = (t_i.min10 >= MIN10_MAX);
        end
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode controller.
//   CLK1, RESET          : clock, synchronous active-high reset
//   tick_1hz             : one-cycle pulse per second
//   btn_*                : one-cycle button pulses (start, lap, clear, set, sel, inc)
//   disp_*               : registered BCD digits for the display driver
//   cursor               : SET-mode digit index
//   state                : FSM state code (sw_state_e)
//   running / alarm      : state decodes for RUN / ALARM
//   overflow             : sticky 59:59 -> 00:00 wrap flag, cleared by btn_clear
//   lap_cnt / lap_view   : number of stored laps; display shows a stored lap
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned LAP_DEPTH = 4
) (
  input  logic                             CLK1,
  input  logic                             RESET,
  input  logic                             tick_1hz,
  input  logic                             btn_start,
  input  logic                             btn_lap,
  input  logic                             btn_clear,
  input  logic                             btn_set,
  input  logic                             btn_sel,
  input  logic                             btn_inc,
  output logic [3:0]                       disp_min10,
  output logic [3:0]                       disp_min01,
  output logic [3:0]                       disp_sec10,
  output logic [3:0]                       disp_sec01,
  output logic [1:0]                       cursor,
  output logic [2:0]                       state,
  output logic                             running,
  output logic                             alarm,
  output logic                             overflow,
  output logic [$clog2(LAP_DEPTH+1)-1:0]   lap_cnt,
  output logic                             lap_view
);

  localparam int unsigned CntW = $clog2(LAP_DEPTH + 1);
  localparam int unsigned PtrW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(LAP_DEPTH);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(LAP_DEPTH - 1);
  localparam logic [PtrW:0]   DepthW  = (PtrW + 1)'(LAP_DEPTH);

  sw_state_e       state_q, state_d;
  mmss_t           time_q, time_d;
  mmss_t           target_q, target_d;
  mmss_t           disp_q, disp_d;
  logic [1:0]      cursor_q, cursor_d;
  logic            ovf_q, ovf_d;
  logic [CntW-1:0] lap_cnt_q, lap_cnt_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic            lap_view_q, lap_view_d;
  logic [PtrW-1:0] view_sel_q, view_sel_d;  // logical index, 0 = oldest lap
  mmss_t           lap_mem_q [LAP_DEPTH];
  logic            lap_we;

  mmss_t           time_inc;
  logic            time_wrap;
  logic            alarm_hit;
  logic [PtrW-1:0] oldest;
  logic [PtrW:0]   rd_sum;
  logic [PtrW-1:0] rd_idx;

  bcd_mmss_inc u_inc (
    .t_i    (time_q),
    .t_o    (time_inc),
    .wrap_o (time_wrap)
  );

  assign alarm_hit = (target_q != '0) && (time_inc == target_q);

  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    target_d   = target_q;
    cursor_d   = cursor_q;
    ovf_d      = ovf_q;
    lap_cnt_d  = lap_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    lap_view_d = lap_view_q;
    view_sel_d = view_sel_q;
    lap_we     = 1'b0;

    if (btn_clear && (state_q != StSet)) begin
      state_d    = StIdle;
      time_d     = '0;
      ovf_d      = 1'b0;
      lap_cnt_d  = '0;
      wr_ptr_d   = '0;
      lap_view_d = 1'b0;
      view_sel_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (btn_set)        state_d = StSet;
          else if (btn_start) state_d = StRun;
        end
        StRun: begin
          if (tick_1hz) begin
            time_d = time_inc;
            if (time_wrap) ovf_d = 1'b1;
            if (alarm_hit) begin
              time_d  = target_q;
              state_d = StAlarm;
            end
          end
          // set has no effect here but still outranks start and lap
          if (!btn_set) begin
            if (btn_start) begin
              if (!(tick_1hz && alarm_hit)) state_d = StPause;
            end else if (btn_lap) begin
              lap_we   = 1'b1;  // records time_q, i.e. before any same-cycle tick
              wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
              if (lap_cnt_q != CntMax) lap_cnt_d = lap_cnt_q + CntW'(1);
            end
          end
        end
        StPause: begin
          if (!btn_set) begin
            if (btn_start) begin
              state_d    = StRun;
              lap_view_d = 1'b0;
              view_sel_d = '0;
            end else if (btn_lap && (lap_cnt_q != '0)) begin
              if (!lap_view_q) begin
                lap_view_d = 1'b1;
                view_sel_d = '0;
              end else if (CntW'(view_sel_q) + CntW'(1) >= lap_cnt_q) begin
                lap_view_d = 1'b0;
                view_sel_d = '0;
              end else begin
                view_sel_d = view_sel_q + PtrW'(1);
              end
            end
          end
        end
        StSet: begin
          if (btn_set) state_d = StIdle;
          if (btn_sel) cursor_d = cursor_q + 2'd1;
          if (btn_inc) begin
            unique case (cursor_q)
              CUR_SEC01: target_d.sec01 = digit_inc_wrap(target_q.sec01, UNIT_MAX);
              CUR_SEC10: target_d.sec10 = digit_inc_wrap(target_q.sec10, SEC10_MAX);
              CUR_MIN01: target_d.min01 = digit_inc_wrap(target_q.min01, UNIT_MAX);
              CUR_MIN10: target_d.min10 = digit_inc_wrap(target_q.min10, MIN10_MAX);
              default:   target_d = target_q;
            endcase
          end
        end
        StAlarm: begin
          if (!btn_set && btn_start) begin
            state_d = StIdle;
            time_d  = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Lap store is only read in PAUSE, where pointer and count are stable.
  always_comb begin
    oldest = (lap_cnt_q == CntMax) ? wr_ptr_q : '0;
    rd_sum = {1'b0, oldest} + {1'b0, view_sel_d};
    if (rd_sum >= DepthW) rd_sum = rd_sum - DepthW;
    rd_idx = rd_sum[PtrW-1:0];
  end

  always_comb begin
    if (state_d == StSet)                       disp_d = target_d;
    else if ((state_d == StPause) && lap_view_d) disp_d = lap_mem_q[rd_idx];
    else                                         disp_d = time_d;
  end

  always_ff @(posedge CLK1) begin
    if (RESET) begin
      state_q    <= StIdle;
      time_q     <= '0;
      target_q   <= '0;
      disp_q     <= '0;
      cursor_q   <= '0;
      ovf_q      <= 1'b0;
      lap_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      lap_view_q <= 1'b0;
      view_sel_q <= '0;
      for (int i = 0; i < int'(LAP_DEPTH); i++) lap_mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      target_q   <= target_d;
      disp_q     <= disp_d;
      cursor_q   <= cursor_d;
      ovf_q      <= ovf_d;
      lap_cnt_q  <= lap_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      lap_view_q <= lap_view_d;
      view_sel_q <= view_sel_d;
      if (lap_we) lap_mem_q[wr_ptr_q] <= time_q;
    end
  end

  assign disp_min10 = disp_q.min10;
  assign disp_min01 = disp_q.min01;
  assign disp_sec10 = disp_q.sec10;
  assign disp_sec01 = disp_q.sec01;
  assign cursor     = cursor_q;
  assign state      = state_q;
  assign running    = (state_q == StRun);
  assign alarm      = (state_q == StAlarm);
  assign overflow   = ovf_q;
  assign lap_cnt    = lap_cnt_q;
  assign lap_view   = lap_view_q;

endmodule
